// File: rtl/cpu64_l2_line_reader.sv
// cpu64_l2_line_reader: streams one 64B L2 line (8 x 64-bit beats) from the
// data/tag arrays to a valid/ready consumer, one beat per cycle sustained.
// Optional feature macro: CPU64_L2_LRD_CRITWORD_EN (critical-word-first start).
module cpu64_l2_line_reader (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [7:0]  req_index_i,
   input  logic [3:0]  req_way_i,
   input  logic [2:0]  req_word_i,
   output logic [7:0]  arr_index_o,
   output logic [2:0]  arr_word_sel_o,
   output logic [3:0]  arr_way_sel_o,
   input  logic [63:0] arr_rdata_i,
   input  logic [49:0] arr_tag_i,
   output logic        beat_valid_o,
   input  logic        beat_ready_i,
   output logic [63:0] beat_data_o,
   output logic [2:0]  beat_word_o,
   output logic        beat_last_o,
   output logic [63:0] line_addr_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {StIdle, StLoad, StSend} state_e;

   state_e      r_state;
   state_e      w_state_d;
   logic [7:0]  r_index;
   logic [3:0]  r_way;
   logic [2:0]  r_word;
   logic [2:0]  r_cnt;
   logic [63:0] r_data;
   logic [49:0] r_tag;
   logic [7:0]  r_line_index;
   logic [2:0]  w_start_word;
   logic        w_req_hs;
   logic        w_beat_hs;

`ifdef CPU64_L2_LRD_CRITWORD_EN
   assign w_start_word = req_word_i;
`else
   logic w_unused_word;
   assign w_unused_word = ^req_word_i;
   assign w_start_word  = 3'd0;
`endif

   assign w_req_hs  = req_valid_i && (r_state == StIdle);
   assign w_beat_hs = beat_ready_i && (r_state == StSend);

   // Array addressing: in SEND the next word is pre-fetched so a handshake
   // can capture it immediately and keep one beat per cycle.
   assign arr_index_o    = r_index;
   assign arr_way_sel_o  = r_way;
   assign arr_word_sel_o = (r_state == StSend) ? r_word + 3'd1 : r_word;

   assign req_ready_o  = (r_state == StIdle);
   assign busy_o       = (r_state != StIdle);
   assign beat_valid_o = (r_state == StSend);
   assign beat_data_o  = r_data;
   assign beat_word_o  = r_word;
   assign beat_last_o  = (r_cnt == 3'd7) && beat_valid_o;
   // Index kept separately from r_index so the address holds until the next LOAD.
   assign line_addr_o  = {r_tag, r_line_index, 6'b0};

   // Next-state logic for the IDLE -> LOAD -> SEND sequence.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:  if (req_valid_i) w_state_d = StLoad;
         StLoad:  w_state_d = StSend;
         StSend:  if (beat_ready_i && (r_cnt == 3'd7)) w_state_d = StIdle;
         default: w_state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any line in flight.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= StIdle;
         r_index      <= 8'd0;
         r_way        <= 4'd0;
         r_word       <= 3'd0;
         r_cnt        <= 3'd0;
         r_data       <= 64'd0;
         r_tag        <= 50'd0;
         r_line_index <= 8'd0;
      end else begin
         r_state <= w_state_d;
         unique case (r_state)
            StIdle: begin
               if (w_req_hs) begin
                  r_index <= req_index_i;
                  r_way   <= req_way_i;
                  r_word  <= w_start_word;
                  r_cnt   <= 3'd0;
               end
            end
            StLoad: begin
               r_data       <= arr_rdata_i;
               r_tag        <= arr_tag_i;
               r_line_index <= r_index;
            end
            StSend: begin
               if (w_beat_hs && (r_cnt != 3'd7)) begin
                  r_data <= arr_rdata_i;
                  r_word <= r_word + 3'd1;
                  r_cnt  <= r_cnt + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cpu64_l2_line_reader.md
CPU64_L2_LINE_READER -- requirements
Module: cpu64_l2_line_reader

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (256 sets, 16 ways, 8 x 64-bit words per 64B line, 50-bit tag).
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  1  line-read request valid.
REQ-005 req_ready_o  output  1  request accepted when req_valid_i && req_ready_o.
REQ-006 req_index_i  input  8  set index of line to read.
REQ-007 req_way_i  input  4  way of line to read.
REQ-008 req_word_i  input  3  starting word; used only with CPU64_L2_LRD_CRITWORD_EN.
REQ-009 arr_index_o  output  8  set index driven to the L2 data/tag arrays.
REQ-010 arr_word_sel_o  output  3  word select driven to the arrays.
REQ-011 arr_way_sel_o  output  4  way select driven to the arrays.
REQ-012 arr_rdata_i  input  64  selected-way word from the arrays, combinational from arr_* outputs.
REQ-013 arr_tag_i  input  50  selected-way tag from the arrays, combinational from arr_index_o/arr_way_sel_o.
REQ-014 beat_valid_o  output  1  output data beat valid.
REQ-015 beat_ready_i  input  1  consumer accepts beat when beat_valid_o && beat_ready_i.
REQ-016 beat_data_o  output  64  beat payload.
REQ-017 beat_word_o  output  3  word index within line of current beat.
REQ-018 beat_last_o  output  1  current beat is the 8th beat of the line.
REQ-019 line_addr_o  output  64  {tag, index, 6'b0} of line being streamed.
REQ-020 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, SEND; req_ready_o SHALL be 1 only in IDLE.
REQ-022 IDLE: on request handshake, latch index, way, start word into registers, clear the 3-bit sent counter, go to LOAD.
REQ-023 LOAD: arr_* SHALL present {latched index, current word, latched way}; arr_rdata_i SHALL be registered into beat_data_o and arr_tag_i into line_addr_o[63:14]; next state SEND.
REQ-024 SEND: beat_valid_o SHALL be 1; arr_word_sel_o SHALL present current word + 1 (mod 8).
REQ-025 SEND with beat_ready_i=0: beat_data_o, beat_word_o, beat_last_o SHALL hold unchanged.
REQ-026 SEND with handshake and sent counter < 7: capture arr_rdata_i into beat_data_o, increment word (mod 8) and sent counter, remain in SEND (one beat per cycle sustained).
REQ-027 SEND with handshake and sent counter = 7: go to IDLE; beat_valid_o SHALL be 0 the next cycle.
REQ-028 beat_last_o SHALL equal (sent counter = 7) && beat_valid_o.
REQ-029 Latency: request accepted in cycle T, first beat valid in T+2, last beat no earlier than T+9; next request acceptable in the cycle after the last handshake.
REQ-030 Array contents SHALL be sampled per beat at capture time; the block SHALL NOT block or detect concurrent array writes.
REQ-031 line_addr_o SHALL hold its value from first LOAD until the next request's LOAD; arr_index_o/arr_way_sel_o SHALL hold latched values in IDLE.

Reset
REQ-032 With rst_ni low at a clock edge: state IDLE, all outputs and registers 0 (req_ready_o=1 the cycle after), regardless of operation in progress; partially streamed lines SHALL be discarded with no further beats.

Configuration
REQ-033 Macro CPU64_L2_LRD_CRITWORD_EN defined: start word = req_word_i, beats wrap mod 8 (critical-word-first).
REQ-034 Macro undefined: req_word_i ignored, start word = 0, beats in order 0..7; all other behaviour identical.

Verification
REQ-035 Reset then request index 0x12, way 5, beat_ready_i=1 -> beats in cycles T+2..T+9, words 0..7, beat_last_o only on word 7, line_addr_o={tag[0x12][5],0x12,6'b0}.
REQ-036 CRITWORD_EN, req_word_i=5 -> beat_word_o sequence 5,6,7,0,1,2,3,4, beat_last_o on word 4.
REQ-037 beat_ready_i toggling 1,0,0,1 -> data/word held during stall, no beat dropped or duplicated, 8 beats total.
REQ-038 rst_ni low during 3rd beat -> beat_valid_o=0 next cycle, busy_o=0, req_ready_o=1, no further beats.
REQ-039 Two back-to-back requests (way 0 then way 15, same index) -> second accepted the cycle after first's last handshake, 16 beats correct data, no overlap.
